piso_serializer: RTL and testbench

Parallel-in, serial-out serializer, the transmit-side counterpart of the block that shifts one bit per clock into a DATA_WIDTH-bit word. It accepts a parallel word over a valid/ready handshake and emits it one bit per clock with a valid qualifier and a last-bit marker. A word accepted during the final bit of the current word starts on the next cycle, giving gapless back-to-back streams. It sits between a word-wide producer and the bit-serial link.

---
 rtl/piso_serializer.sv | 96 +++++++++
 tb/tb_piso_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: takes a word over a valid/ready handshake and
// emits it one bit per clock with valid/last qualifiers, back-to-back without gaps.
module piso_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  busy
);

    localparam int             CW         = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST_IDX   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  PENULT_IDX = CW'(DATA_WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_dout;
    logic                  r_valid;
    logic                  r_last;

    logic                  w_at_last;
    logic                  w_accept;
    logic                  w_din_first;
    logic [DATA_WIDTH-1:0] w_din_rest;
    logic                  w_shift_first;
    logic [DATA_WIDTH-1:0] w_shift_rest;

    assign w_at_last = (r_state == SHIFT) && (r_cnt == LAST_IDX);
    assign din_ready = !reset && ((r_state == IDLE) || w_at_last);
    assign w_accept  = din_valid && din_ready;

    // The first bit goes straight to the output flop on load; the register keeps the rest.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_din_first   = din[DATA_WIDTH-1];
            assign w_din_rest    = din << 1;
            assign w_shift_first = r_shift[DATA_WIDTH-1];
            assign w_shift_rest  = r_shift << 1;
        end else begin : g_lsb_first
            assign w_din_first   = din[0];
            assign w_din_rest    = din >> 1;
            assign w_shift_first = r_shift[0];
            assign w_shift_rest  = r_shift >> 1;
        end
    endgenerate

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_shift <= w_din_rest;
            r_dout  <= w_din_first;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_at_last) begin
                r_state <= IDLE;
                r_dout  <= 1'b0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= w_shift_rest;
                r_dout  <= w_shift_first;
                r_last  <= (r_cnt == PENULT_IDX);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign busy       = r_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (16-bit MSB-first, 16-bit LSB-first, 2-bit)
// compared every cycle against a bit-queue reference model.
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  din_valid;
    logic [15:0] din [3];
    logic [2:0]  din_ready;
    logic [2:0]  dout;
    logic [2:0]  dout_valid;
    logic [2:0]  dout_last;
    logic [2:0]  busy;

    int vectors     = 0;
    int miscompares = 0;

    bit q0[$];
    bit q1[$];
    bit q2[$];
    logic [2:0] accepted;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_msb16 (
        .clk(clk), .reset(reset), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
        .dout_last(dout_last[0]), .busy(busy[0])
    );

    piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) u_lsb16 (
        .clk(clk), .reset(reset), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
        .dout_last(dout_last[1]), .busy(busy[1])
    );

    piso_serializer #(.DATA_WIDTH(2), .MSB_FIRST(1'b1)) u_msb2 (
        .clk(clk), .reset(reset), .din(din[2][1:0]), .din_valid(din_valid[2]),
        .din_ready(din_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
        .dout_last(dout_last[2]), .busy(busy[2])
    );

    // ---------------- reference model: one queue of pending bits per instance ----------------
    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic bit qfront(int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(int k);
        if (qsize(k) > 0) begin
            case (k)
                0:       q0.pop_front();
                1:       q1.pop_front();
                default: q2.pop_front();
            endcase
        end
    endtask

    task automatic qpush(int k, bit b);
        case (k)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic push_word(int k, logic [15:0] w);
        int width;
        bit msb;
        width = (k == 2) ? 2 : 16;
        msb   = (k != 1);
        for (int i = 0; i < width; i++)
            qpush(k, w[msb ? (width - 1 - i) : i]);
    endtask

    task automatic clear_models();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Observed vs expected {din_ready, busy, dout_valid, dout_last, dout}
    task automatic check_all(string tag);
        logic [4:0] obs;
        logic [4:0] exp;
        bit         has;
        for (int k = 0; k < 3; k++) begin
            has = (qsize(k) > 0);
            exp = {(!reset && qsize(k) <= 1), has, has, (qsize(k) == 1), (has ? qfront(k) : 1'b0)};
            obs = {din_ready[k], busy[k], dout_valid[k], dout_last[k], dout[k]};
            vectors++;
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s inst%0d {ready,busy,valid,last,dout} observed=%b expected=%b",
                       tag, k, obs, exp);
            end
        end
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic tick();
        logic [2:0] acc;
        for (int k = 0; k < 3; k++)
            acc[k] = din_valid[k] && !reset && (qsize(k) <= 1);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            qpop(k);
            if (acc[k])
                push_word(k, din[k]);
        end
        accepted = acc;
        @(negedge clk);
        check_all("cycle");
    endtask

    // Present a word on one instance and hold din_valid until it is taken (left high on return).
    task automatic send(int k, logic [15:0] w);
        int guard;
        din[k]       = w;
        din_valid[k] = 1'b1;
        guard        = 0;
        do begin
            tick();
            guard++;
        end while (!accepted[k] && guard < 100);
        if (!accepted[k]) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout inst%0d word=%h not accepted within 100 cycles", k, w);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset_pulse();
        reset = 1'b1;
        clear_models();
        #1;
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("reset_release");
    endtask

    initial begin
        reset     = 1'b1;
        din_valid = '0;
        for (int k = 0; k < 3; k++)
            din[k] = '0;
        accepted  = '0;

        repeat (3) @(negedge clk);
        check_all("reset_state");
        reset = 1'b0;
        #1;
        check_all("ready_after_reset");

        // Single word A5C3, MSB first
        send(0, 16'hA5C3);
        din_valid[0] = 1'b0;
        idle(18);

        // Back-to-back FFFF then 0001; din changes while the first word is in flight
        send(0, 16'hFFFF);
        send(0, 16'h0001);
        din_valid[0] = 1'b0;
        idle(18);

        // Data stability: 7FFF presented during 8000's transmission
        send(0, 16'h8000);
        send(0, 16'h7FFF);
        din_valid[0] = 1'b0;
        idle(18);

        // LSB first, 0003
        send(1, 16'h0003);
        din_valid[1] = 1'b0;
        idle(18);

        // Minimum width stream 10, 01
        send(2, 16'h0002);
        send(2, 16'h0001);
        din_valid[2] = 1'b0;
        idle(4);

        // Reset during bit 6 of FFFF, then a zero word
        send(0, 16'hFFFF);
        din_valid[0] = 1'b0;
        idle(5);
        async_reset_pulse();
        send(0, 16'h0000);
        din_valid[0] = 1'b0;
        idle(18);

        // Reset asserted with din_valid high: nothing may be accepted
        din_valid = 3'b111;
        din[0] = 16'h1234;
        din[1] = 16'h4321;
        din[2] = 16'h0003;
        async_reset_pulse();
        din_valid = '0;
        idle(2);

        // Randomized traffic on all three instances, with occasional async resets
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                din_valid[k] = ($urandom_range(0, 3) != 0);
                din[k]       = 16'($urandom);
            end
            if ($urandom_range(0, 199) == 0)
                async_reset_pulse();
            tick();
        end
        din_valid = '0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
